exec_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 16-bit mini-CPU datapath around the Execute stage. It fetches instructions over a req/ack instruction-memory handshake and decodes opcode/operand. It drives register-file read/write addresses and write enable, latches the N/Z flags, and resolves JMP and conditional branches. It owns the PC and the instruction register; Execute and the register file stay combinational.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_decode.sv | 32 +++
 rtl/exec_sequencer.sv | 164 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-CPU sequencer: opcodes, FSM states, IR fields.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD      = 4'b0000;
  localparam logic [3:0] OP_ALU_FIRST = 4'b0001;
  localparam logic [3:0] OP_ALU_LAST  = 4'b0110;
  localparam logic [3:0] OP_JMP       = 4'b0111;
  localparam logic [3:0] OP_BRN       = 4'b1000;
  localparam logic [3:0] OP_BRZ       = 4'b1001;
  localparam logic [3:0] OP_HALT      = 4'b1111;

  // Instruction word field positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: IR in, instruction class and RF write target out.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_alu,
  output logic        is_load,
  output logic        is_jmp,
  output logic        is_brn,
  output logic        is_brz,
  output logic        is_halt,
  output logic [3:0]  waddr,
  output logic        writes_rf
);

  logic [3:0] opcode;

  assign opcode = ir[OPC_MSB:OPC_LSB];

  // Classify the opcode and pick the destination register
  always_comb begin
    is_alu    = is_alu_op(opcode);
    is_load   = (opcode == OP_LOAD);
    is_jmp    = (opcode == OP_JMP);
    is_brn    = (opcode == OP_BRN);
    is_brz    = (opcode == OP_BRZ);
    is_halt   = (opcode == OP_HALT);
    writes_rf = is_alu || is_load;
    waddr     = is_alu ? ir[RD_MSB:RD_LSB] : 4'h0;
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM around the Execute stage: fetch, decode, execute,
// writeback; owns PC, IR, N/Z flags and the retired-instruction counter.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  output logic [3:0]       ex_opcode,
  output logic [11:0]      ex_operand,
  input  logic [15:0]      ex_result,
  input  logic             ex_n,
  input  logic             ex_z,
  output logic [3:0]       rf_raddr1,
  output logic [3:0]       rf_raddr2,
  output logic [3:0]       rf_waddr,
  output logic [15:0]      rf_wdata,
  output logic             rf_we,
  output logic             flag_n,
  output logic             flag_z,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             imem_req_q, imem_req_d;
  logic             rf_we_q, rf_we_d;
  logic             halted_q, halted_d;
  logic             retire;

  logic       dec_is_alu, dec_is_load, dec_is_jmp, dec_is_brn, dec_is_brz, dec_is_halt;
  logic       dec_writes_rf;
  logic [3:0] dec_waddr;

  instr_decode u_decode (
    .ir        (ir_q),
    .is_alu    (dec_is_alu),
    .is_load   (dec_is_load),
    .is_jmp    (dec_is_jmp),
    .is_brn    (dec_is_brn),
    .is_brz    (dec_is_brz),
    .is_halt   (dec_is_halt),
    .waddr     (dec_waddr),
    .writes_rf (dec_writes_rf)
  );

  // Next-state, PC/IR/flag/counter updates; strobes derive from the next state
  // so they register alongside it.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flag_n_d  = flag_n_q;
    flag_z_d  = flag_z_q;
    wdata_d   = wdata_q;
    retired_d = retired_q;
    retire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        wdata_d = ex_result;
        if (dec_is_alu) begin
          flag_n_d = ex_n;
          flag_z_d = ex_z;
          state_d  = S_WRITEBACK;
        end else if (dec_is_load) begin
          state_d = S_WRITEBACK;
        end else if (dec_is_halt) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else begin
          retire = 1'b1;
          if (dec_is_jmp || (dec_is_brn && flag_n_q) || (dec_is_brz && flag_z_q))
            pc_d = ir_q[PC_W-1:0];
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_WRITEBACK: begin
        retire  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire && (retired_q != '1))
      retired_d = retired_q + CNT_W'(1);

    imem_req_d = (state_d == S_FETCH);
    rf_we_d    = (state_d == S_WRITEBACK) && dec_writes_rf;
    halted_d   = (state_d == S_HALT);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      flag_n_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      wdata_q    <= '0;
      retired_q  <= '0;
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      flag_n_q   <= flag_n_d;
      flag_z_q   <= flag_z_d;
      wdata_q    <= wdata_d;
      retired_q  <= retired_d;
      imem_req_q <= imem_req_d;
      rf_we_q    <= rf_we_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign ex_opcode  = ir_q[OPC_MSB:OPC_LSB];
  assign ex_operand = ir_q[RD_MSB:RS2_LSB];
  assign rf_raddr1  = ir_q[RS1_MSB:RS1_LSB];
  assign rf_raddr2  = ir_q[RS2_MSB:RS2_LSB];
  assign rf_waddr   = dec_waddr;
  assign rf_wdata   = wdata_q;
  assign rf_we      = rf_we_q;
  assign flag_n     = flag_n_q;
  assign flag_z     = flag_z_q;
  assign halted     = halted_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer; the bench plays instruction memory and Execute.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [3:0]  ex_opcode;
  logic [11:0] ex_operand;
  logic [15:0] ex_result = '0;
  logic        ex_n = 1'b0;
  logic        ex_z = 1'b0;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_we;
  logic        flag_n, flag_z, halted;
  logic [3:0]  retired;

  int unsigned checks = 0;
  int unsigned failures = 0;

  exec_sequencer #(.PC_W(12), .RESET_PC(12'h000), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ex_opcode  (ex_opcode),
    .ex_operand (ex_operand),
    .ex_result  (ex_result),
    .ex_n       (ex_n),
    .ex_z       (ex_z),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_we      (rf_we),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a fetch request, then ack it with instr in that cycle.
  task automatic fetch(input logic [15:0] instr, output bit ok);
    int unsigned n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    ok = (imem_req === 1'b1);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({imem_req, rf_we, halted, flag_n, flag_z} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=00000", {imem_req, rf_we, halted, flag_n, flag_z});
    end
    checks++;
    if ({imem_addr, retired, rf_wdata} !== 32'h0) begin
      failures++;
      $display("FAIL reset_values addr=%h retired=%h wdata=%h exp all 0", imem_addr, retired, rf_wdata);
    end
    checks++;
    if ({ex_opcode, ex_operand, rf_raddr1, rf_raddr2, rf_waddr} !== 28'h0) begin
      failures++;
      $display("FAIL reset_ir_fields got=%h exp=0", {ex_opcode, ex_operand, rf_raddr1, rf_raddr2, rf_waddr});
    end
    reset = 1'b0;
    run   = 1'b1;
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 12'h000}) begin
      failures++;
      $display("FAIL first_fetch req=%b addr=%h exp req=1 addr=000", imem_req, imem_addr);
    end
  endtask

  task automatic test_load();
    bit ok;
    ex_result = 16'h0ABC;
    fetch(16'h0ABC, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL load_fetch_timeout got=0 exp=1"); end
    checks++;
    if ({ex_opcode, ex_operand, rf_raddr1, rf_raddr2, imem_req, imem_addr} !== {16'h0ABC, 4'hB, 4'hC, 1'b0, 12'h001}) begin
      failures++;
      $display("FAIL load_decode op=%h opnd=%h r1=%h r2=%h req=%b addr=%h exp 0/abc/b/c/0/001",
               ex_opcode, ex_operand, rf_raddr1, rf_raddr2, imem_req, imem_addr);
    end
    step(); // EXECUTE
    checks++;
    if (rf_we !== 1'b0) begin failures++; $display("FAIL load_we_early got=%b exp=0", rf_we); end
    step(); // WRITEBACK
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, retired} !== {1'b1, 4'h0, 16'h0ABC, 4'h0}) begin
      failures++;
      $display("FAIL load_writeback we=%b waddr=%h wdata=%h retired=%h exp 1/0/0abc/0", rf_we, rf_waddr, rf_wdata, retired);
    end
    step(); // FETCH
    checks++;
    if ({rf_we, imem_req, imem_addr, retired} !== {1'b0, 1'b1, 12'h001, 4'h1}) begin
      failures++;
      $display("FAIL load_retire we=%b req=%b addr=%h retired=%h exp 0/1/001/1", rf_we, imem_req, imem_addr, retired);
    end
  endtask

  task automatic test_alu_flags();
    bit ok;
    ex_result = 16'h8000;
    ex_n = 1'b1;
    ex_z = 1'b0;
    fetch(16'h1312, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL alu_fetch_timeout got=0 exp=1"); end
    step(); // EXECUTE
    checks++;
    if ({flag_n, flag_z} !== 2'b00) begin failures++; $display("FAIL alu_flags_early got=%b exp=00", {flag_n, flag_z}); end
    step(); // WRITEBACK
    ex_n = 1'b0;
    ex_z = 1'b1;
    checks++;
    if ({flag_n, flag_z, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b0, 1'b1, 4'h3, 16'h8000}) begin
      failures++;
      $display("FAIL alu_writeback n=%b z=%b we=%b waddr=%h wdata=%h exp 1/0/1/3/8000", flag_n, flag_z, rf_we, rf_waddr, rf_wdata);
    end
    step(); // FETCH
    checks++;
    if ({rf_we, flag_n, flag_z, retired, imem_addr} !== {1'b0, 1'b1, 1'b0, 4'h2, 12'h002}) begin
      failures++;
      $display("FAIL alu_after we=%b n=%b z=%b retired=%h addr=%h exp 0/1/0/2/002", rf_we, flag_n, flag_z, retired, imem_addr);
    end
  endtask

  task automatic test_load_keeps_flags();
    bit ok;
    ex_result = 16'h0055;
    ex_n = 1'b0;
    ex_z = 1'b1;
    fetch(16'h0055, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL load2_fetch_timeout got=0 exp=1"); end
    step();
    step(); // WRITEBACK
    checks++;
    if ({flag_n, flag_z, rf_we, rf_waddr} !== {1'b1, 1'b0, 1'b1, 4'h0}) begin
      failures++;
      $display("FAIL load_keeps_flags n=%b z=%b we=%b waddr=%h exp 1/0/1/0", flag_n, flag_z, rf_we, rf_waddr);
    end
    step();
    checks++;
    if ({retired, imem_addr} !== {4'h3, 12'h003}) begin
      failures++;
      $display("FAIL load2_retire retired=%h addr=%h exp 3/003", retired, imem_addr);
    end
  endtask

  task automatic test_branches();
    bit ok;
    fetch(16'h8040, ok); // BRN, flag_n=1 -> taken
    checks++;
    if (!ok) begin failures++; $display("FAIL brn_fetch_timeout got=0 exp=1"); end
    step(); // EXECUTE
    checks++;
    if ({rf_we, imem_req} !== 2'b00) begin failures++; $display("FAIL brn_execute we/req=%b exp=00", {rf_we, imem_req}); end
    step(); // FETCH, 3-cycle instruction
    checks++;
    if ({imem_req, imem_addr, retired} !== {1'b1, 12'h040, 4'h4}) begin
      failures++;
      $display("FAIL brn_taken req=%b addr=%h retired=%h exp 1/040/4", imem_req, imem_addr, retired);
    end
    fetch(16'h9050, ok); // BRZ, flag_z=0 -> not taken
    checks++;
    if (!ok) begin failures++; $display("FAIL brz_fetch_timeout got=0 exp=1"); end
    step();
    step();
    checks++;
    if ({imem_req, imem_addr, retired} !== {1'b1, 12'h041, 4'h5}) begin
      failures++;
      $display("FAIL brz_untaken req=%b addr=%h retired=%h exp 1/041/5", imem_req, imem_addr, retired);
    end
  endtask

  task automatic test_jmp_wrap();
    bit ok;
    fetch(16'h7FFF, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL jmp_fetch_timeout got=0 exp=1"); end
    step();
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 12'hFFF}) begin
      failures++;
      $display("FAIL jmp_target req=%b addr=%h exp 1/fff", imem_req, imem_addr);
    end
    fetch(16'hA000, ok); // NOP at 0xFFF
    checks++;
    if (imem_addr !== 12'h000) begin failures++; $display("FAIL pc_wrap got=%h exp=000", imem_addr); end
    step();
    step();
    checks++;
    if ({imem_req, imem_addr, retired, rf_we} !== {1'b1, 12'h000, 4'h7, 1'b0}) begin
      failures++;
      $display("FAIL nop_after req=%b addr=%h retired=%h we=%b exp 1/000/7/0", imem_req, imem_addr, retired, rf_we);
    end
  endtask

  task automatic test_delayed_ack();
    int unsigned req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req === 1'b1 && imem_addr === 12'h000) req_cycles++;
      step();
    end
    if (imem_req === 1'b1 && imem_addr === 12'h000) req_cycles++;
    ex_result  = 16'h0001;
    ex_n       = 1'b0;
    ex_z       = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'h1456;
    step(); // DECODE
    checks++;
    if ({req_cycles, imem_req} !== {32'd6, 1'b0}) begin
      failures++;
      $display("FAIL delayed_req_hold cycles=%0d req_after=%b exp 6/0", req_cycles, imem_req);
    end
    imem_rdata = 16'hF000; // spurious ack still high during DECODE
    step(); // EXECUTE
    imem_ack   = 1'b0;
    imem_rdata = '0;
    checks++;
    if ({ex_opcode, ex_operand, imem_addr} !== {16'h1456, 12'h001}) begin
      failures++;
      $display("FAIL spurious_ack op=%h opnd=%h addr=%h exp 1/456/001", ex_opcode, ex_operand, imem_addr);
    end
    step(); // WRITEBACK
    checks++;
    if ({rf_we, rf_waddr, flag_n, flag_z, rf_wdata} !== {1'b1, 4'h4, 1'b0, 1'b0, 16'h0001}) begin
      failures++;
      $display("FAIL delayed_writeback we=%b waddr=%h n=%b z=%b wdata=%h exp 1/4/0/0/0001", rf_we, rf_waddr, flag_n, flag_z, rf_wdata);
    end
    step();
    checks++;
    if ({imem_req, imem_addr, retired} !== {1'b1, 12'h001, 4'h8}) begin
      failures++;
      $display("FAIL delayed_retire req=%b addr=%h retired=%h exp 1/001/8", imem_req, imem_addr, retired);
    end
  endtask

  task automatic test_run_drop();
    bit ok;
    fetch(16'hA000, ok);
    run = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL rundrop_fetch_timeout got=0 exp=1"); end
    step();
    step(); // IDLE
    checks++;
    if ({imem_req, imem_addr, retired} !== {1'b0, 12'h002, 4'h9}) begin
      failures++;
      $display("FAIL run_drop_idle req=%b addr=%h retired=%h exp 0/002/9", imem_req, imem_addr, retired);
    end
    step();
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_stays got=%b exp=0", imem_req); end
    run = 1'b1;
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 12'h002}) begin
      failures++;
      $display("FAIL idle_restart req=%b addr=%h exp 1/002", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt();
    bit ok;
    int unsigned bad = 0;
    fetch(16'hF000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL halt_fetch_timeout got=0 exp=1"); end
    step(); // EXECUTE
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL halt_early got=%b exp=0", halted); end
    step(); // HALT
    checks++;
    if ({halted, imem_req, retired} !== {1'b1, 1'b0, 4'hA}) begin
      failures++;
      $display("FAIL halt_enter halted=%b req=%b retired=%h exp 1/0/a", halted, imem_req, retired);
    end
    for (int i = 0; i < 8; i++) begin
      imem_ack = (i % 2 == 0);
      step();
      if ({halted, imem_req, rf_we, imem_addr, retired} !== {3'b100, 12'h003, 4'hA}) bad++;
    end
    imem_ack = 1'b0;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL halt_sticky bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_async_reset();
    bit ok;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
    fetch(16'hA000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_fetch_timeout got=0 exp=1"); end
    step();
    step(); // FETCH at 001
    checks++;
    if ({imem_req, imem_addr, retired} !== {1'b1, 12'h001, 4'h1}) begin
      failures++;
      $display("FAIL rst_pre req=%b addr=%h retired=%h exp 1/001/1", imem_req, imem_addr, retired);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr, retired, halted, ex_opcode} !== {1'b0, 12'h000, 4'h0, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL async_reset req=%b addr=%h retired=%h halted=%b op=%h exp 0/000/0/0/0", imem_req, imem_addr, retired, halted, ex_opcode);
    end
    run = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_to_idle req=%b exp=0", imem_req); end
    run = 1'b1;
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 12'h000}) begin
      failures++;
      $display("FAIL reset_restart req=%b addr=%h exp 1/000", imem_req, imem_addr);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int unsigned timeouts = 0;
    for (int i = 0; i < 17; i++) begin
      fetch(16'h7000, ok);
      if (!ok) timeouts++;
      step();
      step();
      if (i == 14) begin
        checks++;
        if (retired !== 4'hF) begin failures++; $display("FAIL retired_reach_max got=%h exp=f", retired); end
      end
    end
    checks++;
    if (timeouts !== 0) begin failures++; $display("FAIL sat_fetch_timeouts got=%0d exp=0", timeouts); end
    checks++;
    if ({retired, imem_addr, imem_req} !== {4'hF, 12'h000, 1'b1}) begin
      failures++;
      $display("FAIL retired_saturate retired=%h addr=%h req=%b exp f/000/1", retired, imem_addr, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu_flags();
    test_load_keeps_flags();
    test_branches();
    test_jmp_wrap();
    test_delayed_ack();
    test_run_drop();
    test_halt();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
